reg_file_16x32: RTL and testbench

- 16-entry x 32-bit general-purpose register file.
- Sits directly upstream of the ALU operand stage; read port A drives the Ra operand and read port B drives the Rb operand of the ALU logic units (not32, and32, etc.).
- Register writes come from the Z/MDR writeback path.
- Port A supports R0 zero-gating via ba_out for base-address calculation in load/store.

---
 rtl/reg_file_16x32.sv | 49 ++++
 tb/tb_reg_file_16x32.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_16x32.sv
// reg_file_16x32: 16x32 register file feeding the ALU Ra/Rb operands, written from Z/MDR writeback
// Ports:
//   clock      rising-edge clock
//   clear      asynchronous active-high reset; zeroes all registers and r0_zero_a
//   wr_en      write enable, sampled on the rising edge
//   wr_addr    destination register index
//   wr_data    write data
//   rd_addr_a  port A index (Ra operand)
//   rd_addr_b  port B index (Rb operand)
//   ba_out     forces port A to zero when it addresses R0 (base-address calculation)
//   rd_data_a  port A combinational read data
//   rd_data_b  port B combinational read data
//   r0_zero_a  registered flag: previous cycle's port A read was zero-gated
module reg_file_16x32 #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    input  logic              ba_out,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              r0_zero_a
);
    logic [DATA_W-1:0] regs [DEPTH];
    logic gate_a, fwd_a, fwd_b;
    assign gate_a = ba_out && rd_addr_a == '0;
    assign fwd_a  = BYPASS != 0 && wr_en && wr_addr == rd_addr_a;
    assign fwd_b  = BYPASS != 0 && wr_en && wr_addr == rd_addr_b;
    // clear masks the outputs so a pending write is not forwarded while storage is held at zero
    assign rd_data_a = (clear || gate_a) ? '0 : fwd_a ? wr_data : regs[rd_addr_a];
    assign rd_data_b = clear ? '0 : fwd_b ? wr_data : regs[rd_addr_b];
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            r0_zero_a <= 1'b0;
        end else begin
            if (wr_en) regs[wr_addr] <= wr_data;
            r0_zero_a <= gate_a;
        end
    end
endmodule

// File: tb/tb_reg_file_16x32.sv
// tb_reg_file_16x32: scoreboard bench for reg_file_16x32 with bypass on (dut1) and off (dut0)
module tb_reg_file_16x32;
    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  rd_addr_a = '0;
    logic [3:0]  rd_addr_b = '0;
    logic        ba_out = 1'b0;
    logic [31:0] a1, b1, a0, b0;
    logic        z1, z0;
    logic [31:0] model [16];
    logic [31:0] exp_q [$];
    logic [31:0] e;
    int checks = 0;
    int errors = 0;

    reg_file_16x32 #(.BYPASS(1)) dut1 (
        .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .ba_out(ba_out),
        .rd_data_a(a1), .rd_data_b(b1), .r0_zero_a(z1)
    );
    reg_file_16x32 #(.BYPASS(0)) dut0 (
        .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .ba_out(ba_out),
        .rd_data_a(a0), .rd_data_b(b0), .r0_zero_a(z0)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clock);
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) model[i] = '0;
        @(negedge clock);
        rd_addr_a = 4'd3; rd_addr_b = 4'd9;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL reset_a got %h exp %h", a1, e); end
        e = exp_q.pop_front(); checks++;
        if (b1 !== e) begin errors++; $display("FAIL reset_b got %h exp %h", b1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, z1} !== e) begin errors++; $display("FAIL reset_z got %h exp %h", z1, e); end
        clear = 1'b0;
    endtask

    task automatic test_clear_mid();
        do_write(4'd5, 32'hDEADBEEF);
        rd_addr_a = 4'd5;
        exp_q.push_back(model[5]);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL preload_r5 got %h exp %h", a1, e); end
        #2;
        clear = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL clear_mid_a1 got %h exp %h", a1, e); end
        e = exp_q.pop_front(); checks++;
        if (a0 !== e) begin errors++; $display("FAIL clear_mid_a0 got %h exp %h", a0, e); end
        @(negedge clock);
        clear = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL cleared_r5 got %h exp %h", a1, e); end
    endtask

    task automatic test_write_read_all();
        for (int k = 0; k < 16; k++) do_write(4'(k), 32'h11111111 * k);
        for (int k = 0; k < 16; k++) begin
            rd_addr_a = 4'(k); rd_addr_b = 4'(15 - k);
            exp_q.push_back(32'h11111111 * k); exp_q.push_back(32'h11111111 * (15 - k));
            exp_q.push_back(32'h11111111 * k); exp_q.push_back(32'h11111111 * (15 - k));
            #1;
            e = exp_q.pop_front(); checks++;
            if (a1 !== e) begin errors++; $display("FAIL rd_all_a1[%0d] got %h exp %h", k, a1, e); end
            e = exp_q.pop_front(); checks++;
            if (b1 !== e) begin errors++; $display("FAIL rd_all_b1[%0d] got %h exp %h", 15 - k, b1, e); end
            e = exp_q.pop_front(); checks++;
            if (a0 !== e) begin errors++; $display("FAIL rd_all_a0[%0d] got %h exp %h", k, a0, e); end
            e = exp_q.pop_front(); checks++;
            if (b0 !== e) begin errors++; $display("FAIL rd_all_b0[%0d] got %h exp %h", 15 - k, b0, e); end
        end
        rd_addr_a = 4'd3; rd_addr_b = 4'd12;
        exp_q.push_back(32'h33333333); exp_q.push_back(32'hCCCCCCCC);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL rd_r3_a got %h exp %h", a1, e); end
        e = exp_q.pop_front(); checks++;
        if (b1 !== e) begin errors++; $display("FAIL rd_r12_b got %h exp %h", b1, e); end
    endtask

    task automatic test_r0_gating();
        do_write(4'd0, 32'hAAAAAAAA);
        rd_addr_a = 4'd0; rd_addr_b = 4'd0; ba_out = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'hAAAAAAAA);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL gate_a got %h exp %h", a1, e); end
        e = exp_q.pop_front(); checks++;
        if (b1 !== e) begin errors++; $display("FAIL gate_b got %h exp %h", b1, e); end
        exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        @(posedge clock); #1;
        e = exp_q.pop_front(); checks++;
        if ({31'b0, z1} !== e) begin errors++; $display("FAIL r0_zero_set1 got %h exp %h", z1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, z0} !== e) begin errors++; $display("FAIL r0_zero_set0 got %h exp %h", z0, e); end
        @(negedge clock);
        ba_out = 1'b0;
        exp_q.push_back(32'hAAAAAAAA);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL ungated_a got %h exp %h", a1, e); end
        @(negedge clock);
        rd_addr_a = 4'd4; ba_out = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(model[4]);
        @(posedge clock); #1;
        e = exp_q.pop_front(); checks++;
        if ({31'b0, z1} !== e) begin errors++; $display("FAIL r0_zero_clr got %h exp %h", z1, e); end
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL ba_nonzero_addr got %h exp %h", a1, e); end
        @(negedge clock);
        ba_out = 1'b0;
    endtask

    task automatic test_bypass();
        do_write(4'd7, 32'h0);
        @(negedge clock);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h55555555; rd_addr_a = 4'd7; rd_addr_b = 4'd7;
        exp_q.push_back(32'h55555555); exp_q.push_back(32'h55555555); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL bypass_a1 got %h exp %h", a1, e); end
        e = exp_q.pop_front(); checks++;
        if (b1 !== e) begin errors++; $display("FAIL bypass_b1 got %h exp %h", b1, e); end
        e = exp_q.pop_front(); checks++;
        if (a0 !== e) begin errors++; $display("FAIL nobypass_pre got %h exp %h", a0, e); end
        model[7] = 32'h55555555;
        exp_q.push_back(32'h55555555);
        @(posedge clock); #1;
        e = exp_q.pop_front(); checks++;
        if (a0 !== e) begin errors++; $display("FAIL nobypass_post got %h exp %h", a0, e); end
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic test_gate_bypass();
        @(negedge clock);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
        rd_addr_a = 4'd0; rd_addr_b = 4'd0; ba_out = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'hFFFFFFFF); exp_q.push_back(model[0]);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL gate_over_bypass_a1 got %h exp %h", a1, e); end
        e = exp_q.pop_front(); checks++;
        if (a0 !== e) begin errors++; $display("FAIL gate_over_bypass_a0 got %h exp %h", a0, e); end
        e = exp_q.pop_front(); checks++;
        if (b1 !== e) begin errors++; $display("FAIL gate_bypass_b1 got %h exp %h", b1, e); end
        e = exp_q.pop_front(); checks++;
        if (b0 !== e) begin errors++; $display("FAIL gate_bypass_b0 got %h exp %h", b0, e); end
        model[0] = 32'hFFFFFFFF;
        @(negedge clock);
        wr_en = 1'b0; ba_out = 1'b0;
        exp_q.push_back(model[0]);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL r0_after_write got %h exp %h", a1, e); end
    endtask

    task automatic test_clear_collision();
        @(negedge clock);
        rd_addr_a = 4'd9; rd_addr_b = 4'd9;
        exp_q.push_back(32'h99999999);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL pre_collision_r9 got %h exp %h", a1, e); end
        @(negedge clock);
        clear = 1'b1; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h12345678;
        for (int i = 0; i < 16; i++) model[i] = '0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL clear_masks_bypass got %h exp %h", a1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, z1} !== e) begin errors++; $display("FAIL clear_z got %h exp %h", z1, e); end
        @(negedge clock);
        clear = 1'b0; wr_en = 1'b0;
        exp_q.push_back(model[9]); exp_q.push_back(model[9]); exp_q.push_back(model[9]);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a1 !== e) begin errors++; $display("FAIL collision_r9_a1 got %h exp %h", a1, e); end
        e = exp_q.pop_front(); checks++;
        if (a0 !== e) begin errors++; $display("FAIL collision_r9_a0 got %h exp %h", a0, e); end
        e = exp_q.pop_front(); checks++;
        if (b1 !== e) begin errors++; $display("FAIL collision_r9_b1 got %h exp %h", b1, e); end
        do_write(4'd9, 32'h0BADF00D);
        exp_q.push_back(model[9]);
        #1;
        e = exp_q.pop_front(); checks++;
        if (a0 !== e) begin errors++; $display("FAIL write_after_clear got %h exp %h", a0, e); end
    endtask

    initial begin
        test_reset();
        test_clear_mid();
        test_write_read_all();
        test_r0_gating();
        test_bypass();
        test_gate_bypass();
        test_clear_collision();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
